// File: rtl/pci_chk_pkg.sv
// Shared definitions for the PCI protocol checker: check indices,
// bus FSM state encodings and a priority helper for first-error capture.
package pci_chk_pkg;

  localparam int NCHK = 8;

  // Bit position of each rule inside err_pulse / err_sticky / err_count
  typedef enum logic [2:0] {
    CHK_AD_CBE_FALL   = 3'd0,  // AD/C_BE_ unknown on FRAME_ fall
    CHK_AD_CBE_XFER   = 3'd1,  // AD/C_BE_ unknown during a data transfer
    CHK_FRAME_IRDY    = 3'd2,  // FRAME_ released while IRDY_ not asserted
    CHK_TRDY_DEVSEL   = 3'd3,  // TRDY_ asserted without DEVSEL_
    CHK_CBE_X         = 3'd4,  // C_BE_ unknown in address/data states
    CHK_MASTER_ABORT  = 3'd5,  // no DEVSEL_ within the timeout window
    CHK_IRDY_WITHDRAW = 3'd6,  // IRDY_ withdrawn before its transfer
    CHK_BACK2BACK     = 3'd7   // new FRAME_ fall with no idle clock
  } chk_id_e;

  // Bus FSM encodings, kept as plain 3-bit constants for legacy consumers
  typedef logic [2:0] bus_state_e;
  localparam bus_state_e ST_IDLE  = 3'd0;
  localparam bus_state_e ST_ADDR  = 3'd1;
  localparam bus_state_e ST_WAIT  = 3'd2;
  localparam bus_state_e ST_DATA  = 3'd3;
  localparam bus_state_e ST_LAST  = 3'd4;
  localparam bus_state_e ST_ABORT = 3'd5;
  localparam bus_state_e ST_TURN  = 3'd6;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [2:0] lowest_set(input logic [NCHK-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NCHK - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pci_chk_sat_counter.sv
// Saturating event counter: synchronous clear has priority but still
// records an increment arriving in the same clock.
module pci_chk_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear-then-apply, otherwise increment until the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_ONE : CNT_ZERO;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pci_protocol_checker.sv
// Passive PCI bus monitor: follows each transaction with a small FSM,
// evaluates eight rule checks every clock and reports registered pulses,
// sticky flags, saturating per-rule counts and the first failing rule.
module pci_protocol_checker
  import pci_chk_pkg::*;
#(
  parameter int AD_W       = 32,
  parameter int CNT_W      = 8,
  parameter int DEVSEL_TMO = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FRAME_,
  input  logic                  IRDY_,
  input  logic                  TRDY_,
  input  logic                  DEVSEL_,
  input  logic [AD_W/8-1:0]     C_BE_,
  input  logic [AD_W-1:0]       AD,
  input  logic [NCHK-1:0]       chk_en,
  input  logic                  clr,
  output logic [NCHK-1:0]       err_pulse,
  output logic [NCHK-1:0]       err_sticky,
  output logic [NCHK*CNT_W-1:0] err_count,
  output logic                  first_valid,
  output logic [2:0]            first_id,
  output logic [CNT_W-1:0]      xfer_count,
  output logic [CNT_W-1:0]      trx_count,
  output logic [2:0]            bus_state
);

  localparam int TMO_W = $clog2(DEVSEL_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(DEVSEL_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DEVSEL_TMO - 1);

  // Bus history (idle bus is all-ones) and tracking state
  logic             frame_q, irdy_q, xfer_q;
  bus_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NCHK-1:0]  pulse_q, sticky_q, sticky_d;
  logic             first_valid_q, first_valid_d;
  logic [2:0]       first_id_q, first_id_d;
  logic [CNT_W-1:0] xfer_cnt_q, trx_cnt_q;

  logic            fell_f, rose_f, xfer, cbe_x, bus_x, tmo_hit;
  logic [NCHK-1:0] viol, pulse_d;

  assign fell_f  = frame_q & ~FRAME_;
  assign rose_f  = ~frame_q & FRAME_;
  assign xfer    = ~IRDY_ & ~TRDY_;
  // Unknown-value detection only has meaning in a four-state simulator
  assign cbe_x   = $isunknown(C_BE_);
  assign bus_x   = $isunknown(AD) | cbe_x;
  // The DEVSEL_TMO-th consecutive WAIT clock without DEVSEL_ is the abort point
  assign tmo_hit = (state_q == ST_WAIT) & DEVSEL_ & (tmo_q == TMO_LAST);

  // Raw rule evaluation on the current bus sample
  always_comb begin
    viol                    = {NCHK{1'b0}};
    viol[CHK_AD_CBE_FALL]   = fell_f & bus_x;
    viol[CHK_AD_CBE_XFER]   = xfer & bus_x;
    viol[CHK_FRAME_IRDY]    = rose_f & IRDY_;
    viol[CHK_TRDY_DEVSEL]   = ~TRDY_ & DEVSEL_;
    viol[CHK_CBE_X]         = ((state_q == ST_ADDR) | (state_q == ST_DATA)) & cbe_x;
    viol[CHK_MASTER_ABORT]  = tmo_hit;
    viol[CHK_IRDY_WITHDRAW] = ~irdy_q & IRDY_ & ~xfer_q;
    viol[CHK_BACK2BACK]     = fell_f & ~irdy_q;
  end

  assign pulse_d = viol & chk_en;

  // Transaction FSM; a FRAME_ fall restarts tracking from any state
  always_comb begin
    state_d = state_q;
    if (fell_f) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ADDR:  state_d = ST_WAIT;
        ST_WAIT:  state_d = !DEVSEL_ ? ST_DATA : (tmo_hit ? ST_ABORT : ST_WAIT);
        ST_DATA:  state_d = (FRAME_ && !IRDY_) ? ST_LAST : ST_DATA;
        ST_LAST:  state_d = xfer ? ST_TURN : ST_LAST;
        ST_ABORT: state_d = (FRAME_ && IRDY_) ? ST_TURN : ST_ABORT;
        ST_TURN:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // DEVSEL_ timeout: zero outside WAIT so every WAIT entry starts fresh
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != ST_WAIT) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (DEVSEL_ && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Sticky flags and first-error capture; clr clears then records this clock
  always_comb begin
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    if (clr) begin
      sticky_d      = pulse_d;
      first_valid_d = |pulse_d;
      first_id_d    = lowest_set(pulse_d);
    end else if (!first_valid_q && (|pulse_d)) begin
      sticky_d      = sticky_q | pulse_d;
      first_valid_d = 1'b1;
      first_id_d    = lowest_set(pulse_d);
    end else begin
      sticky_d      = sticky_q | pulse_d;
    end
  end

  // State, history and reporting registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q       <= 1'b1;
      irdy_q        <= 1'b1;
      xfer_q        <= 1'b0;
      state_q       <= ST_IDLE;
      tmo_q         <= {TMO_W{1'b0}};
      pulse_q       <= {NCHK{1'b0}};
      sticky_q      <= {NCHK{1'b0}};
      first_valid_q <= 1'b0;
      first_id_q    <= 3'd0;
      xfer_cnt_q    <= {CNT_W{1'b0}};
      trx_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      frame_q       <= FRAME_;
      irdy_q        <= IRDY_;
      xfer_q        <= xfer;
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      pulse_q       <= pulse_d;
      sticky_q      <= sticky_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
      xfer_cnt_q    <= xfer_cnt_q + (xfer ? CNT_W'(1) : CNT_W'(0));
      trx_cnt_q     <= trx_cnt_q + (fell_f ? CNT_W'(1) : CNT_W'(0));
    end
  end

  // One saturating counter per rule
  for (genvar gi = 0; gi < NCHK; gi++) begin : g_cnt
    pci_chk_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr),
      .inc_i (pulse_d[gi]),
      .cnt_o (err_count[gi*CNT_W +: CNT_W])
    );
  end

  assign err_pulse   = pulse_q;
  assign err_sticky  = sticky_q;
  assign first_valid = first_valid_q;
  assign first_id    = first_id_q;
  assign xfer_count  = xfer_cnt_q;
  assign trx_count   = trx_cnt_q;
  assign bus_state   = state_q;

endmodule
